// File: rtl/alu_operand_pkg.sv
// Shared types and helpers for the ALU operand register.
package alu_operand_pkg;

   // Operand register lifecycle: nothing loaded, holding an operand, or frozen by hold.
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      LOADED = 2'd1,
      FROZEN = 2'd2
   } operand_state_t;

   // Widest enable vector the helper below accepts.
   localparam int MAX_SRC = 32;

   // True when more than one bit of v is set: clearing the lowest set bit leaves something behind.
   function automatic logic popcount_gt1(input logic [MAX_SRC-1:0] v);
      return (v & (v - MAX_SRC'(1))) != '0;
   endfunction

endpackage

// File: rtl/operand_source_select.sv
// Combinational source picker: lowest-index enabled source wins, optionally inverted.
module operand_source_select
   import alu_operand_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NUM_SRC = 3
) (
   input  logic [NUM_SRC*WIDTH-1:0] src_in,
   input  logic [NUM_SRC-1:0]       src_en,
   input  logic [NUM_SRC-1:0]       invert_en,
   output logic                     sel_valid,
   output logic [WIDTH-1:0]         sel_data,
   output logic                     multi_hit
);

   // Each source after its own inversion; only the selected one is ever used,
   // so an invert bit without a matching enable has no effect.
   logic [WIDTH-1:0] cand [NUM_SRC];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
         assign cand[gi] = invert_en[gi] ? ~src_in[gi*WIDTH +: WIDTH]
                                         :  src_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Priority mux: scan from the top down so the lowest enabled index is written last.
   always_comb begin
      sel_data = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_en[i]) begin
            sel_data = cand[i];
         end
      end
   end

   assign sel_valid = |src_en;
   assign multi_hit = popcount_gt1(MAX_SRC'(src_en));

endmodule

// File: rtl/alu_operand_register.sv
// ALU operand input register: N selectable sources with per-source invert,
// empty/loaded/frozen tracking, a previous-operand shadow and a sticky conflict flag.
module alu_operand_register
   import alu_operand_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               NUM_SRC     = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               BYPASS      = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*WIDTH-1:0] src_IN,
   input  logic [NUM_SRC-1:0]       src_EN,
   input  logic [NUM_SRC-1:0]       invert_EN,
   input  logic                     hold_IN,
   input  logic                     clear_IN,
   output logic [WIDTH-1:0]         value_OUT,
   output logic [WIDTH-1:0]         prev_OUT,
   output logic                     valid_OUT,
   output logic                     frozen_OUT,
   output logic                     conflict_OUT
);

   operand_state_t   state_reg, state_next;
   logic [WIDTH-1:0] value_reg, value_next;
   logic [WIDTH-1:0] prev_reg, prev_next;
   logic             valid_reg, valid_next;
   logic             conflict_reg, conflict_next;

   logic             sel_valid;
   logic [WIDTH-1:0] sel_data;
   logic             multi_hit;
   logic             load_accept;

   operand_source_select #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC)
   ) u_select (
      .src_in    (src_IN),
      .src_en    (src_EN),
      .invert_en (invert_EN),
      .sel_valid (sel_valid),
      .sel_data  (sel_data),
      .multi_hit (multi_hit)
   );

   // A load lands only when nothing of higher precedence is active this cycle.
   assign load_accept = sel_valid && !hold_IN && !clear_IN && !reset;

   // State and datapath registers; reset forces EMPTY even while hold is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= EMPTY;
         value_reg    <= RESET_VALUE;
         prev_reg     <= RESET_VALUE;
         valid_reg    <= 1'b0;
         conflict_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         value_reg    <= value_next;
         prev_reg     <= prev_next;
         valid_reg    <= valid_next;
         conflict_reg <= conflict_next;
      end
   end

   // Next-state logic in precedence order: clear, then hold, then load/release.
   always_comb begin
      state_next    = state_reg;
      value_next    = value_reg;
      prev_next     = prev_reg;
      valid_next    = valid_reg;
      conflict_next = conflict_reg;

      if (clear_IN) begin
         // Clear wipes contents; a simultaneous hold still leaves us frozen (but empty).
         value_next    = RESET_VALUE;
         prev_next     = RESET_VALUE;
         valid_next    = 1'b0;
         conflict_next = 1'b0;
         state_next    = hold_IN ? FROZEN : EMPTY;
      end else if (hold_IN) begin
         state_next = FROZEN;
      end else if (load_accept) begin
         // Also covers the release cycle out of FROZEN.
         prev_next  = value_reg;
         value_next = sel_data;
         valid_next = 1'b1;
         state_next = LOADED;
         if (multi_hit) begin
            conflict_next = 1'b1;
         end
      end else if (state_reg == FROZEN) begin
         state_next = valid_reg ? LOADED : EMPTY;
      end
   end

   assign prev_OUT   = prev_reg;
   assign valid_OUT  = valid_reg;
   assign frozen_OUT = (state_reg == FROZEN);

   generate
      if (BYPASS) begin : g_bypass
         assign value_OUT = load_accept ? sel_data : value_reg;
      end else begin : g_registered
         assign value_OUT = value_reg;
      end

      // With a single source two enables can never coincide.
      if (NUM_SRC == 1) begin : g_single_src
         assign conflict_OUT = 1'b0;
      end else begin : g_multi_src
         assign conflict_OUT = conflict_reg;
      end
   endgenerate

endmodule
